// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter for sequence-detector stimulus.
//
// Accepts a word over a valid/ready handshake and shifts len bits out on X, LSB first.
// The word is repeated in_rep+1 times back-to-back. Optional GAP idle cycles follow the
// last repetition.
//
// Optional feature: define SEQ_PATTERN_TX_PARITY_EN to append one even-parity bit
// after every repetition. This bit is the XOR of that repetition's len bits.
//
// Ports:
//   clk       in   clock, all state on posedge
//   reset     in   asynchronous active-low reset
//   in_valid  in   request valid
//   in_ready  out  high only in idle and out of reset
//   in_data   in   WIDTH bits to send, in_data[0] first
//   in_len    in   bits per repetition, 0 means WIDTH
//   in_rep    in   extra repetitions (word sent in_rep+1 times)
//   X         out  registered serial output
//   busy      out  high from accept until return to idle
//   done      out  one-cycle pulse on the first idle cycle after a transfer
module seq_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REP_W = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH+1)-1:0] in_len,
  input  logic [REP_W-1:0]           in_rep,
  output logic                       X,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned LW = $clog2(WIDTH + 1);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
`ifdef SEQ_PATTERN_TX_PARITY_EN
    StPar,
`endif
    StGap
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;   // original word, reloaded for each repetition
  logic [WIDTH-1:0] sh_q;     // bits still to send in this repetition
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    cnt_q;    // index of the bit currently on X
  logic [REP_W-1:0] rep_q;
  logic [GW-1:0]    gap_q;
  logic             x_q;
  logic             busy_q;
  logic             done_q;
`ifdef SEQ_PATTERN_TX_PARITY_EN
  logic             par_q;    // XOR of bits already sent in this repetition
`endif

  logic last_bit;
  logic rep_end;

  assign last_bit = (cnt_q == len_q - LW'(1));

`ifdef SEQ_PATTERN_TX_PARITY_EN
  assign rep_end = (state_q == StPar);
`else
  assign rep_end = (state_q == StSend) && last_bit;
`endif

  // Combinational so that it drops with reset as soon as reset is asserted.
  assign in_ready = (state_q == StIdle) && reset;
  assign X        = x_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q <= StSend;
            busy_q  <= 1'b1;
            data_q  <= in_data;
            sh_q    <= in_data >> 1;
            x_q     <= in_data[0];
            len_q   <= (in_len == '0) ? LW'(WIDTH) : in_len;
            rep_q   <= in_rep;
            cnt_q   <= '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
          end
        end
        StSend: begin
          if (!last_bit) begin
            cnt_q <= cnt_q + LW'(1);
            x_q   <= sh_q[0];
            sh_q  <= sh_q >> 1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
            par_q <= par_q ^ x_q;
`endif
          end
`ifdef SEQ_PATTERN_TX_PARITY_EN
          else begin
            state_q <= StPar;
            x_q     <= par_q ^ x_q;
          end
`endif
        end
`ifdef SEQ_PATTERN_TX_PARITY_EN
        StPar: ;  // repetition end handled below
`endif
        StGap: begin
          if (gap_q == GW'(GAP - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      // End of one repetition: restart the word, or wind down.
      if (rep_end) begin
        if (rep_q != '0) begin
          state_q <= StSend;
          rep_q   <= rep_q - REP_W'(1);
          cnt_q   <= '0;
          x_q     <= data_q[0];
          sh_q    <= data_q >> 1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
          par_q   <= 1'b0;
`endif
        end else if (GAP == 0) begin
          state_q <= StIdle;
          x_q     <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= StGap;
          x_q     <= 1'b0;
          gap_q   <= '0;
        end
      end
    end
  end

endmodule
